// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } db_state_t;

    // Counter width for a value range, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, press/release debounce FSM,
// long-press and auto-repeat counters; all outputs registered.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned DB_TICKS     = 255,
    parameter int unsigned HOLD_TICKS   = 50000,
    parameter int unsigned REPEAT_TICKS = 10000,
    parameter int unsigned REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tick,
    input  logic button,
    output logic valid_ff,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_ff
);

    localparam int unsigned HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned DB_W     = clog2_min1(DB_TICKS + 1);
    localparam int unsigned HOLD_W   = clog2_min1(HOLD_MAX + 1);
    localparam logic [DB_W-1:0]   DB_LIM   = DB_W'(DB_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] REP_LIM  = HOLD_W'(REPEAT_TICKS);
    localparam logic              REL_LVL  = (ACTIVE_LOW != 0);

    logic              sync1, sync2, pressed;
    db_state_t         state, state_nx;
    logic [DB_W-1:0]   db_cnt, db_nx, db_inc;
    logic [HOLD_W-1:0] hold_cnt, hold_nx, hold_inc;
    logic              valid_nx, long_nx, press_nx, rel_nx, rep_nx;

    assign pressed  = sync2 ^ REL_LVL;
    assign db_inc   = (db_cnt == '1) ? db_cnt : db_cnt + 1'b1;
    assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        db_nx    = db_cnt;
        hold_nx  = hold_cnt;
        valid_nx = valid_ff;
        long_nx  = long_ff;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        rep_nx   = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        if (DB_TICKS == 1) begin
                            state_nx = HELD;
                            valid_nx = 1'b1;
                            press_nx = 1'b1;
                            hold_nx  = '0;
                            db_nx    = '0;
                        end else begin
                            state_nx = PRESS_DB;
                            db_nx    = DB_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        state_nx = IDLE;
                        db_nx    = '0;
                    end else if (db_inc == DB_LIM) begin
                        state_nx = HELD;
                        valid_nx = 1'b1;
                        press_nx = 1'b1;
                        hold_nx  = '0;
                        db_nx    = '0;
                    end else begin
                        db_nx = db_inc;
                    end
                end
                // HELD and REPEAT share release entry; they differ only in hold limit.
                HELD, REPEAT: begin
                    if (!pressed) begin
                        if (DB_TICKS == 1) begin
                            state_nx = IDLE;
                            valid_nx = 1'b0;
                            long_nx  = 1'b0;
                            rel_nx   = 1'b1;
                            db_nx    = '0;
                            hold_nx  = '0;
                        end else begin
                            state_nx = RELEASE_DB;
                            db_nx    = DB_W'(1);
                        end
                    end else if (state == REPEAT) begin
                        if (hold_inc == REP_LIM) begin
                            rep_nx  = 1'b1;
                            hold_nx = '0;
                        end else begin
                            hold_nx = hold_inc;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (hold_inc == HOLD_LIM) begin
                            rep_nx   = 1'b1;
                            state_nx = REPEAT;
                            long_nx  = 1'b1;
                            hold_nx  = '0;
                        end else begin
                            hold_nx = hold_inc;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (pressed) begin
                        state_nx = HELD;
                        hold_nx  = '0;
                        long_nx  = 1'b0;
                        db_nx    = '0;
                    end else if (db_inc == DB_LIM) begin
                        state_nx = IDLE;
                        valid_nx = 1'b0;
                        long_nx  = 1'b0;
                        rel_nx   = 1'b1;
                        db_nx    = '0;
                    end else begin
                        db_nx = db_inc;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1         <= REL_LVL;
            sync2         <= REL_LVL;
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            valid_ff      <= 1'b0;
            long_ff       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (!en) begin
                state         <= IDLE;
                db_cnt        <= '0;
                hold_cnt      <= '0;
                valid_ff      <= 1'b0;
                long_ff       <= 1'b0;
                press_pulse   <= 1'b0;
                release_pulse <= 1'b0;
                repeat_pulse  <= 1'b0;
            end else begin
                state         <= state_nx;
                db_cnt        <= db_nx;
                hold_cnt      <= hold_nx;
                valid_ff      <= valid_nx;
                long_ff       <= long_nx;
                press_pulse   <= press_nx;
                release_pulse <= rel_nx;
                repeat_pulse  <= rep_nx;
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer: shared sample-tick prescaler feeding
// independent per-channel debounce/long-press/repeat state machines.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned DB_TICKS     = 255,
    parameter int unsigned HOLD_TICKS   = 50000,
    parameter int unsigned REPEAT_TICKS = 10000,
    parameter int unsigned REPEAT_EN    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] valid_ff,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] long_ff,
    output logic            any_pressed
);

    logic tick;

    generate
        if (TICK_DIV <= 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int unsigned     PS_W    = clog2_min1(TICK_DIV);
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
            logic [PS_W-1:0] ps_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n || !en) begin
                    ps_cnt <= '0;
                end else if (ps_cnt == PS_LAST) begin
                    ps_cnt <= '0;
                end else begin
                    ps_cnt <= ps_cnt + 1'b1;
                end
            end

            assign tick = (ps_cnt == PS_LAST);
        end
    endgenerate

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DB_TICKS    (DB_TICKS),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .REPEAT_EN   (REPEAT_EN)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .tick         (tick),
            .button       (button[i]),
            .valid_ff     (valid_ff[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .long_ff      (long_ff[i])
        );
    end

    assign any_pressed = |valid_ff;

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel button debouncer.
- Successor to the single-channel debouncer for front-panel keys: inputs synchronised, configurable polarity, tick-based sampling, press/release edge pulses, long-press detection and auto-repeat.
- Sits between raw pad inputs and the clock-setting control FSM; one shared prescaler, independent per-channel state.

Parameters:
- N_CH, 4, number of button channels
- ACTIVE_LOW, 1, 1 = button pressed when input is 0; 0 = pressed when 1
- TICK_DIV, 1, clk cycles per sample tick (1 = sample every cycle); >=1
- DB_TICKS, 255, consecutive equal samples required to accept press or release; >=1
- HOLD_TICKS, 50000, ticks in HELD before first repeat pulse; >=1
- REPEAT_TICKS, 10000, ticks between subsequent repeat pulses; >=1
- REPEAT_EN, 1, 0 = no long-press/repeat behaviour (HELD is terminal until release)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; low forces all channels idle
- button  in  N_CH  raw asynchronous button inputs
- valid_ff  out  N_CH  debounced level, high while accepted as pressed
- press_pulse  out  N_CH  one-cycle pulse on accepted press
- release_pulse  out  N_CH  one-cycle pulse on accepted release
- repeat_pulse  out  N_CH  one-cycle pulse on long-press and each auto-repeat
- long_ff  out  N_CH  high while channel is in REPEAT
- any_pressed  out  1  OR of valid_ff

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - All outputs 0.
  - Sync flops at the released level (1 if ACTIVE_LOW, else 0).
  - Prescaler 0, all channels IDLE, all counters 0.
- Reset mid-operation: identical to power-up reset. No pulses are emitted on reset exit.
- Synchroniser: 2 flops per channel. pressed = sync2 XOR ACTIVE_LOW, inverted as needed so 1 means pressed.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 when the count equals TICK_DIV-1; tick is constant 1 when TICK_DIV=1.
  - Counts only while en=1; en=0 clears it.
- Per-channel FSM states: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB.
- The FSM advances only on tick. Counters saturate and never wrap.
  - IDLE: on a tick with pressed=1, go to PRESS_DB with db_cnt=1. If DB_TICKS=1, go directly to HELD instead.
  - PRESS_DB:
    - On a tick with pressed=0, return to IDLE with db_cnt=0 and no pulse.
    - On a tick with pressed=1, increment db_cnt. When it reaches DB_TICKS, enter HELD, set valid_ff=1, pulse press_pulse, and clear hold_cnt.
  - HELD:
    - On a tick with pressed=0, go to RELEASE_DB (db_cnt=1; if DB_TICKS=1 go straight to IDLE with release).
    - On a tick with pressed=1 and REPEAT_EN=1, increment hold_cnt. When it reaches HOLD_TICKS, pulse repeat_pulse, enter REPEAT, set long_ff=1, and clear hold_cnt.
  - REPEAT:
    - On a tick with pressed=1, increment hold_cnt. When it reaches REPEAT_TICKS, pulse repeat_pulse and clear hold_cnt.
    - On a tick with pressed=0, go to RELEASE_DB.
  - RELEASE_DB:
    - valid_ff stays 1 and long_ff stays at its prior value.
    - On a tick with pressed=0, increment db_cnt. When it reaches DB_TICKS, go to IDLE, clear valid_ff and long_ff, and pulse release_pulse.
    - On a tick with pressed=1 (bounce), return to HELD with hold_cnt=0 and long_ff=0; the long-press delay restarts and no pulse is emitted.
- en=0: on the next edge all channels go to IDLE and all outputs are 0. No release_pulse is emitted for a channel forced out of HELD/REPEAT.
- All outputs are registered. Pulses are exactly 1 clk wide regardless of TICK_DIV. press_pulse and release_pulse are never high in the same cycle for a channel.
- Latency:
  - With TICK_DIV=1, valid_ff and press_pulse rise after the (DB_TICKS+2)-th rising edge following a clean input change. Release is symmetric.
  - In general, latency is 2 clk + DB_TICKS ticks, with a tick-phase uncertainty of up to TICK_DIV-1 clk.
- Counter widths: db_cnt is $clog2(DB_TICKS+1). hold_cnt is $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1).

Decomposition:
- debounce_pkg:
  - typedef enum logic[2:0] db_state_t {IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB}.
  - Function clog2_min1 for counter widths.
- Sub-module debounce_channel: one instance per channel (generate loop). It contains the synchroniser, FSM and counters, takes tick and en, and drives the five per-channel outputs.
- The top level holds the prescaler and the any_pressed OR.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clk with button=4'b1111 (ACTIVE_LOW) -> all outputs 0. Release reset -> no pulse within 20 clk.
- Clean press, DB_TICKS=4, TICK_DIV=1:
  - Drive button[0]=0 before edge 0 -> valid_ff[0] and press_pulse[0] go high after edge 5, and the pulse lasts 1 clk.
  - Release -> release_pulse[0] after 6 edges.
- Bounce: with DB_TICKS=4, toggle button[1] every 3 clk for 30 clk -> no press_pulse or valid_ff. Then hold low -> single press_pulse.
- Long press/repeat, HOLD_TICKS=10, REPEAT_TICKS=3, DB_TICKS=2:
  - Hold pressed -> first repeat_pulse 10 clk after press_pulse, then every 3 clk.
  - long_ff is high from the first repeat_pulse until the release pulse.
- Prescaler, TICK_DIV=8, DB_TICKS=3 -> press accepted 2 + 3×8 (±7) clk after the input change, and pulses are 1 clk wide.
- Release bounce in REPEAT, and en drop:
  - A 1-tick release glitch -> no release_pulse, long_ff returns to 0, and repeat restarts after HOLD_TICKS.
  - en=0 mid-HELD -> outputs 0 next edge, no release_pulse.
